// File: rtl/serialize_pkg.sv
// Shared helpers for the serialize_var width-down-converter: chunk counter width
// and the bit offsets of the len and last fields.
package serialize_pkg;

  function automatic int chunk_cw(input int din, input int dout);
    return $clog2(din / dout);
  endfunction

  // len sits directly above the payload in the input word
  function automatic int len_lsb(input int din);
    return din;
  endfunction

  function automatic int din_w(input int din, input int dout);
    return din + chunk_cw(din, dout);
  endfunction

  // last sits directly above the chunk in the output word
  function automatic int last_bit(input int dout);
    return dout;
  endfunction

endpackage

// File: rtl/dti_out_reg.sv
// Generic one-stage valid/ready pipeline register. Accepts a new beat whenever
// the stage is empty or its current beat is leaving this cycle.
module dti_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [WIDTH-1:0] din_data,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout_data
);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;

  assign din_ready  = !valid_r | dout_ready;
  assign dout_valid = valid_r;
  assign dout_data  = data_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (din_ready) begin
      valid_r <= din_valid;
      data_r  <= din_data;
    end
  end

endmodule

// File: rtl/serialize_var.sv
// Splits one DIN-bit word into 1..DIN/DOUT DOUT-bit chunks, count taken from the
// len field of the word, with a last flag and an optional registered output.
//
// Handshake: a beat transfers on a cycle where valid & ready are both high;
// valid/data are held stable while valid is high and ready is low, and ready
// never depends on valid of the same interface.
module serialize_var
  import serialize_pkg::*;
#(
  parameter int DIN       = 16,
  parameter int DOUT      = 4,
  parameter int MSB_FIRST = 0,
  parameter int OUT_REG   = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           din_valid,
  output logic                           din_ready,
  input  logic [din_w(DIN, DOUT)-1:0]    din_data,
  output logic                           dout_valid,
  input  logic                           dout_ready,
  output logic [last_bit(DOUT):0]        dout_data,
  output logic                           busy
);

  localparam int N  = DIN / DOUT;
  localparam int CW = chunk_cw(DIN, DOUT);
  localparam logic [CW-1:0] LEN_MAX = CW'(N - 1);

  if ((DIN % DOUT) != 0 || N < 2) begin : g_bad_params
    $error("serialize_var: DIN must be a multiple of DOUT with DIN/DOUT >= 2");
  end

  logic [DIN-1:0]  payload;
  logic [CW-1:0]   len;
  logic [CW-1:0]   len_e;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   idx;
  logic [DOUT-1:0] chunks [N];
  logic [DOUT-1:0] chunk;
  logic            last_c;
  logic            adv_en;
  logic            advance;

  assign payload = din_data[DIN-1:0];
  assign len     = din_data[len_lsb(DIN) +: CW];
  // Clamp rather than wrap so an oversized len still yields a full word
  assign len_e   = (len > LEN_MAX) ? LEN_MAX : len;
  assign idx     = (MSB_FIRST != 0) ? (len_e - cnt) : cnt;
  assign last_c  = (cnt == len_e);
  assign advance = din_valid & adv_en;
  assign busy    = (cnt != '0);

  for (genvar i = 0; i < N; i++) begin : g_chunks
    assign chunks[i] = payload[i*DOUT +: DOUT];
  end

  always_comb begin
    chunk = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == CW'(i)) chunk = chunks[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= last_c ? '0 : cnt + CW'(1);
    end
  end

  if (OUT_REG != 0) begin : g_reg
    dti_out_reg #(.WIDTH(DOUT + 1)) u_out_reg (
      .clk        (clk),
      .rst        (rst),
      .din_valid  (din_valid),
      .din_ready  (adv_en),
      .din_data   ({last_c, chunk}),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_data  (dout_data)
    );
  end else begin : g_comb
    assign adv_en     = dout_ready;
    assign dout_valid = din_valid;
    assign dout_data  = {last_c, chunk};
  end

  // The word is released only when its final chunk is taken downstream
  assign din_ready = adv_en & last_c;

  property p_dout_stable;
    @(posedge clk) disable iff (rst)
      (dout_valid && !dout_ready) |=> (dout_valid && $stable(dout_data));
  endproperty
  a_dout_stable: assert property (p_dout_stable);

endmodule

// File: tb/tb_serialize_var.sv
// Bench for serialize_var: four parameterisations driven from per-cycle tables,
// with a queue-based scoreboard checking every accepted output chunk.
module tb_serialize_var;

  logic        clk = 1'b0;
  logic        t_rst = 1'b1;
  logic        t_valid = 1'b0;
  logic        t_ready = 1'b0;
  logic [17:0] t_din = '0;
  int          sel = 0;

  always #5 clk = ~clk;

  // a: LSB first comb, b: MSB first comb, c: LSB first registered, d: N=3
  logic        vld_a, vld_b, vld_c, vld_d;
  logic        rdy_a, rdy_b, rdy_c, rdy_d;
  logic        dr_a, dr_b, dr_c, dr_d;
  logic        dv_a, dv_b, dv_c, dv_d;
  logic        bz_a, bz_b, bz_c, bz_d;
  logic [4:0]  dd_a, dd_b, dd_c, dd_d;
  logic        o_dr, o_dv, o_busy;
  logic [4:0]  o_data;

  assign vld_a = t_valid && (sel == 0);
  assign vld_b = t_valid && (sel == 1);
  assign vld_c = t_valid && (sel == 2);
  assign vld_d = t_valid && (sel == 3);
  assign rdy_a = t_ready && (sel == 0);
  assign rdy_b = t_ready && (sel == 1);
  assign rdy_c = t_ready && (sel == 2);
  assign rdy_d = t_ready && (sel == 3);

  serialize_var #(.DIN(16), .DOUT(4), .MSB_FIRST(0), .OUT_REG(0)) u_a (
    .clk(clk), .rst(t_rst), .din_valid(vld_a), .din_ready(dr_a), .din_data(t_din),
    .dout_valid(dv_a), .dout_ready(rdy_a), .dout_data(dd_a), .busy(bz_a));
  serialize_var #(.DIN(16), .DOUT(4), .MSB_FIRST(1), .OUT_REG(0)) u_b (
    .clk(clk), .rst(t_rst), .din_valid(vld_b), .din_ready(dr_b), .din_data(t_din),
    .dout_valid(dv_b), .dout_ready(rdy_b), .dout_data(dd_b), .busy(bz_b));
  serialize_var #(.DIN(16), .DOUT(4), .MSB_FIRST(0), .OUT_REG(1)) u_c (
    .clk(clk), .rst(t_rst), .din_valid(vld_c), .din_ready(dr_c), .din_data(t_din),
    .dout_valid(dv_c), .dout_ready(rdy_c), .dout_data(dd_c), .busy(bz_c));
  serialize_var #(.DIN(12), .DOUT(4), .MSB_FIRST(0), .OUT_REG(0)) u_d (
    .clk(clk), .rst(t_rst), .din_valid(vld_d), .din_ready(dr_d), .din_data(t_din[13:0]),
    .dout_valid(dv_d), .dout_ready(rdy_d), .dout_data(dd_d), .busy(bz_d));

  always_comb begin
    o_dr = dr_a; o_dv = dv_a; o_busy = bz_a; o_data = dd_a;
    case (sel)
      1: begin o_dr = dr_b; o_dv = dv_b; o_busy = bz_b; o_data = dd_b; end
      2: begin o_dr = dr_c; o_dv = dv_c; o_busy = bz_c; o_data = dd_c; end
      3: begin o_dr = dr_d; o_dv = dv_d; o_busy = bz_d; o_data = dd_d; end
      default: ;
    endcase
  end

  typedef struct {
    bit          valid;
    logic [17:0] din;
    bit          ready;
    bit          rst;
    bit          dr;
    bit          dv;
    bit          bz;
    bit          dc;
    logic [4:0]  dd;
  } row_t;

  row_t       rows[$];
  logic [4:0] exp_q[$];
  logic [4:0] exp_v;
  int         n_checks = 0;
  int         n_fail = 0;

  function automatic row_t r(input bit v, input logic [17:0] d, input bit rdy, input bit rs,
                             input bit dr, input bit dv, input bit bz,
                             input bit dc = 1'b0, input logic [4:0] dd = '0);
    row_t x;
    x.valid = v; x.din = d; x.ready = rdy; x.rst = rs;
    x.dr = dr; x.dv = dv; x.bz = bz; x.dc = dc; x.dd = dd;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: every accepted output chunk must match the queue head
  always @(negedge clk) begin
    if (!t_rst && o_dv && t_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL chunk: got %0h, expected no output", o_data);
      end else begin
        exp_v = exp_q.pop_front();
        check($sformatf("chunk sel%0d", sel), {27'd0, o_data}, {27'd0, exp_v});
      end
    end
  end

  task automatic run_rows(input string tname, input int s);
    sel = s;
    for (int i = 0; i < rows.size(); i++) begin
      @(posedge clk); #1;
      t_valid = rows[i].valid;
      t_din   = rows[i].din;
      t_ready = rows[i].ready;
      t_rst   = rows[i].rst;
      @(negedge clk);
      check($sformatf("%s din_ready r%0d", tname, i), {31'd0, o_dr}, {31'd0, rows[i].dr});
      check($sformatf("%s dout_valid r%0d", tname, i), {31'd0, o_dv}, {31'd0, rows[i].dv});
      check($sformatf("%s busy r%0d", tname, i), {31'd0, o_busy}, {31'd0, rows[i].bz});
      if (rows[i].dc) check($sformatf("%s dout_data r%0d", tname, i), {27'd0, o_data}, {27'd0, rows[i].dd});
      if (o_busy) check($sformatf("%s din_valid held r%0d", tname, i), {31'd0, t_valid}, 32'd1);
    end
    @(posedge clk); #1;
    check($sformatf("%s chunks outstanding", tname), exp_q.size(), 0);
    rows.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);

    // Reset state; comb path passes valid through even during reset
    rows.push_back(r(1, 18'h3ABCD, 0, 1, 0, 1, 0));
    rows.push_back(r(0, 18'h3ABCD, 0, 1, 0, 0, 0));
    run_rows("reset_a", 0);
    rows.push_back(r(1, 18'h3ABCD, 0, 1, 0, 0, 0, 1, 5'h00));
    rows.push_back(r(0, 18'h3ABCD, 0, 0, 0, 0, 0, 1, 5'h00));
    run_rows("reset_c", 2);

    // LSB first full word 0xABCD
    exp_q.push_back(5'h0D); exp_q.push_back(5'h0C); exp_q.push_back(5'h0B); exp_q.push_back(5'h1A);
    rows.push_back(r(1, 18'h3ABCD, 1, 0, 0, 1, 0));
    rows.push_back(r(1, 18'h3ABCD, 1, 0, 0, 1, 1));
    rows.push_back(r(1, 18'h3ABCD, 1, 0, 0, 1, 1));
    rows.push_back(r(1, 18'h3ABCD, 1, 0, 1, 1, 1));
    rows.push_back(r(0, 18'h3ABCD, 1, 0, 0, 0, 0));
    run_rows("lsb_full", 0);

    // MSB first, len 1 then len 3
    exp_q.push_back(5'h0C); exp_q.push_back(5'h1D);
    exp_q.push_back(5'h0A); exp_q.push_back(5'h0B); exp_q.push_back(5'h0C); exp_q.push_back(5'h1D);
    rows.push_back(r(1, 18'h1ABCD, 1, 0, 0, 1, 0));
    rows.push_back(r(1, 18'h1ABCD, 1, 0, 1, 1, 1));
    rows.push_back(r(0, 18'h1ABCD, 1, 0, 0, 0, 0));
    rows.push_back(r(1, 18'h3ABCD, 1, 0, 0, 1, 0));
    rows.push_back(r(1, 18'h3ABCD, 1, 0, 0, 1, 1));
    rows.push_back(r(1, 18'h3ABCD, 1, 0, 0, 1, 1));
    rows.push_back(r(1, 18'h3ABCD, 1, 0, 1, 1, 1));
    rows.push_back(r(0, 18'h3ABCD, 1, 0, 0, 0, 0));
    run_rows("msb_first", 1);

    // len 0 under stall, then back-to-back words 0x1234/len0 and 0x5678/len3
    exp_q.push_back(5'h14); exp_q.push_back(5'h14);
    exp_q.push_back(5'h08); exp_q.push_back(5'h07); exp_q.push_back(5'h06); exp_q.push_back(5'h15);
    rows.push_back(r(1, 18'h01234, 0, 0, 0, 1, 0, 1, 5'h14));
    rows.push_back(r(1, 18'h01234, 1, 0, 1, 1, 0));
    rows.push_back(r(1, 18'h01234, 1, 0, 1, 1, 0));
    rows.push_back(r(1, 18'h35678, 1, 0, 0, 1, 0));
    rows.push_back(r(1, 18'h35678, 1, 0, 0, 1, 1));
    rows.push_back(r(1, 18'h35678, 1, 0, 0, 1, 1));
    rows.push_back(r(1, 18'h35678, 1, 0, 1, 1, 1));
    rows.push_back(r(0, 18'h35678, 1, 0, 0, 0, 0));
    run_rows("back2back", 0);

    // Registered output: stall 1,0,0,1 then a second word at full throughput
    exp_q.push_back(5'h0D); exp_q.push_back(5'h0C); exp_q.push_back(5'h0B); exp_q.push_back(5'h1A);
    exp_q.push_back(5'h04); exp_q.push_back(5'h03); exp_q.push_back(5'h02); exp_q.push_back(5'h11);
    rows.push_back(r(1, 18'h3ABCD, 1, 0, 0, 0, 0));
    rows.push_back(r(1, 18'h3ABCD, 1, 0, 0, 1, 1, 1, 5'h0D));
    rows.push_back(r(1, 18'h3ABCD, 0, 0, 0, 1, 1, 1, 5'h0C));
    rows.push_back(r(1, 18'h3ABCD, 0, 0, 0, 1, 1, 1, 5'h0C));
    rows.push_back(r(1, 18'h3ABCD, 1, 0, 0, 1, 1, 1, 5'h0C));
    rows.push_back(r(1, 18'h3ABCD, 1, 0, 1, 1, 1));
    rows.push_back(r(1, 18'h31234, 1, 0, 0, 1, 0, 1, 5'h1A));
    rows.push_back(r(1, 18'h31234, 1, 0, 0, 1, 1));
    rows.push_back(r(1, 18'h31234, 1, 0, 0, 1, 1));
    rows.push_back(r(1, 18'h31234, 1, 0, 1, 1, 1));
    rows.push_back(r(0, 18'h31234, 1, 0, 0, 1, 0, 1, 5'h11));
    rows.push_back(r(0, 18'h31234, 1, 0, 0, 0, 0));
    run_rows("outreg_stall", 2);

    // Reset after the second chunk with the word held: restart from chunk D
    exp_q.push_back(5'h0D); exp_q.push_back(5'h0C);
    exp_q.push_back(5'h0D); exp_q.push_back(5'h0C); exp_q.push_back(5'h0B); exp_q.push_back(5'h1A);
    rows.push_back(r(1, 18'h3ABCD, 1, 0, 0, 0, 0));
    rows.push_back(r(1, 18'h3ABCD, 1, 0, 0, 1, 1));
    rows.push_back(r(1, 18'h3ABCD, 1, 0, 0, 1, 1));
    rows.push_back(r(1, 18'h3ABCD, 0, 1, 0, 1, 1));
    rows.push_back(r(1, 18'h3ABCD, 0, 1, 0, 0, 0));
    rows.push_back(r(1, 18'h3ABCD, 1, 0, 0, 0, 0));
    rows.push_back(r(1, 18'h3ABCD, 1, 0, 0, 1, 1, 1, 5'h0D));
    rows.push_back(r(1, 18'h3ABCD, 1, 0, 0, 1, 1));
    rows.push_back(r(1, 18'h3ABCD, 1, 0, 1, 1, 1));
    rows.push_back(r(0, 18'h3ABCD, 1, 0, 0, 1, 0));
    rows.push_back(r(0, 18'h3ABCD, 1, 0, 0, 0, 0));
    run_rows("mid_reset", 2);

    // N = 3: len 3 clamps to 2, three chunks of 0xABC
    exp_q.push_back(5'h0C); exp_q.push_back(5'h0B); exp_q.push_back(5'h1A);
    rows.push_back(r(1, 18'h03ABC, 1, 0, 0, 1, 0));
    rows.push_back(r(1, 18'h03ABC, 1, 0, 0, 1, 1));
    rows.push_back(r(1, 18'h03ABC, 1, 0, 1, 1, 1));
    rows.push_back(r(0, 18'h03ABC, 1, 0, 0, 0, 0));
    run_rows("clamp_n3", 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
